// File: rtl/periph_bus_pkg.sv
// Shared state type, field widths and SoC slot map for the peripheral bus initiator.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   localparam int PER_ADDR_W = 4;
   localparam int SLOT_W     = 4;

   localparam int SLOT_GPIO  = 0;
   localparam int SLOT_TIMER = 1;
   localparam int SLOT_UART  = 2;

   function automatic logic slot_mapped(input logic [SLOT_W-1:0] slot, input int nslots);
      return (32'(slot) < nslots);
   endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Host request/response channel plus the shared peripheral strobe bus.
interface periph_bus_master_if #(
   parameter int WIDTH  = 32,
   parameter int NSLOTS = 4,
   parameter int ADDR_W = 8
);
   import periph_bus_pkg::*;

   logic                       req_valid;
   logic                       req_ready;
   logic                       req_we;
   logic [ADDR_W-1:0]          req_addr;
   logic [WIDTH-1:0]           req_wdata;
   logic                       resp_valid;
   logic [WIDTH-1:0]           resp_rdata;
   logic                       resp_err;
   logic [PER_ADDR_W-1:0]      per_address;
   logic [WIDTH-1:0]           per_data;
   logic                       per_rden;
   logic                       per_wren;
   logic [NSLOTS-1:0]          per_clken;
   logic [NSLOTS*WIDTH-1:0]    per_q;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, per_q,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output per_address, per_data, per_rden, per_wren, per_clken
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, per_q,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  per_address, per_data, per_rden, per_wren, per_clken
   );

endinterface

// File: rtl/periph_bus_master_rdmux.sv
// NSLOTS:1 selection of peripheral read data by slot index; out-of-range slots read as zero.
module periph_rdmux
   import periph_bus_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NSLOTS = 4
) (
   input  logic [NSLOTS*WIDTH-1:0] q_i,
   input  logic [SLOT_W-1:0]       sel_i,
   output logic [WIDTH-1:0]        data_o
);

   always_comb begin
      data_o = {WIDTH{1'b0}};
      for (int i = 0; i < NSLOTS; i++) begin
         data_o = data_o | (q_i[i*WIDTH +: WIDTH] & {WIDTH{sel_i == SLOT_W'(i)}});
      end
   end

endmodule

// File: rtl/periph_bus_master.sv
// Single-outstanding initiator: decodes a slot, issues one strobe cycle, and returns
// a one-cycle response (write ack, captured read data, or unmapped-slot error).
module periph_bus_master
   import periph_bus_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NSLOTS = 4,
   parameter int ADDR_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   periph_bus_master_if.master bus
);

   state_e                 state_q, state_d;
   logic                   we_q, we_d;
   logic [SLOT_W-1:0]      slot_q, slot_d;
   logic [PER_ADDR_W-1:0]  per_address_q, per_address_d;
   logic [WIDTH-1:0]       per_data_q, per_data_d;
   logic                   per_rden_q, per_rden_d;
   logic                   per_wren_q, per_wren_d;
   logic [NSLOTS-1:0]      per_clken_q, per_clken_d;
   logic                   resp_valid_q, resp_valid_d;
   logic                   resp_err_q, resp_err_d;
   logic [WIDTH-1:0]       resp_rdata_q, resp_rdata_d;
   logic [WIDTH-1:0]       mux_rdata_s;
   logic [NSLOTS-1:0]      req_onehot_s;
   logic [SLOT_W-1:0]      req_slot_s;
   logic                   req_mapped_s;
   logic                   ready_s;
   logic                   accept_s;

   assign req_slot_s   = bus.req_addr[PER_ADDR_W +: SLOT_W];
   assign req_mapped_s = slot_mapped(req_slot_s, NSLOTS);
   assign ready_s      = (state_q == ST_IDLE) & ~rst;
   assign accept_s     = bus.req_valid & ready_s;

   always_comb begin
      req_onehot_s = {NSLOTS{1'b0}};
      for (int i = 0; i < NSLOTS; i++) begin
         req_onehot_s[i] = (req_slot_s == SLOT_W'(i));
      end
   end

   // per_q is only consumed in CAPTURE; peripherals hold stale q in every other cycle.
   periph_rdmux #(.WIDTH(WIDTH), .NSLOTS(NSLOTS)) u_rdmux (
      .q_i    (bus.per_q),
      .sel_i  (slot_q),
      .data_o (mux_rdata_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = req_mapped_s ? ST_STROBE : ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STROBE:  state_d = we_q ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      we_d          = we_q;
      slot_d        = slot_q;
      per_address_d = per_address_q;
      per_data_d    = per_data_q;
      per_clken_d   = {NSLOTS{1'b0}};
      per_rden_d    = 1'b0;
      per_wren_d    = 1'b0;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = {WIDTH{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               we_d   = bus.req_we;
               slot_d = req_slot_s;
               if (req_mapped_s) begin
                  per_clken_d   = req_onehot_s;
                  per_wren_d    = bus.req_we;
                  per_rden_d    = ~bus.req_we;
                  per_address_d = bus.req_addr[PER_ADDR_W-1:0];
                  per_data_d    = bus.req_wdata;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end
            end else begin
               we_d = we_q;
            end
         end
         ST_STROBE: begin
            if (we_q) begin
               resp_valid_d = 1'b1;
            end else begin
               resp_valid_d = 1'b0;
            end
         end
         ST_CAPTURE: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = mux_rdata_s;
         end
         ST_RESP: resp_valid_d = 1'b0;
         default: resp_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q          <= 1'b0;
         slot_q        <= {SLOT_W{1'b0}};
         per_address_q <= {PER_ADDR_W{1'b0}};
         per_data_q    <= {WIDTH{1'b0}};
         per_clken_q   <= {NSLOTS{1'b0}};
         per_rden_q    <= 1'b0;
         per_wren_q    <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= {WIDTH{1'b0}};
      end else begin
         we_q          <= we_d;
         slot_q        <= slot_d;
         per_address_q <= per_address_d;
         per_data_q    <= per_data_d;
         per_clken_q   <= per_clken_d;
         per_rden_q    <= per_rden_d;
         per_wren_q    <= per_wren_d;
         resp_valid_q  <= resp_valid_d;
         resp_err_q    <= resp_err_d;
         resp_rdata_q  <= resp_rdata_d;
      end
   end

   assign bus.req_ready   = ready_s;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.per_address = per_address_q;
   assign bus.per_data    = per_data_q;
   assign bus.per_rden    = per_rden_q;
   assign bus.per_wren    = per_wren_q;
   assign bus.per_clken   = per_clken_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Randomized bench for periph_bus_master: register-file peripherals on the bus and a
// transaction-level model predicting strobes, latency and response contents.
module tb_periph_bus_master;

   localparam int WIDTH  = 32;
   localparam int NSLOTS = 4;
   localparam int ADDR_W = 8;

   logic clk;
   logic rst;
   logic mem_init;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [31:0] pq      [NSLOTS];
   logic [31:0] pregs   [NSLOTS][16];
   logic [31:0] ref_mem [NSLOTS][16];
   int          strobe_cyc_q[$];

   periph_bus_master_if #(.WIDTH(WIDTH), .NSLOTS(NSLOTS), .ADDR_W(ADDR_W)) bus ();

   periph_bus_master #(.WIDTH(WIDTH), .NSLOTS(NSLOTS), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   for (genvar g = 0; g < NSLOTS; g++) begin : g_q
      assign bus.per_q[g*WIDTH +: WIDTH] = pq[g];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] seed_val(input int s, input int r);
      return 32'hC0DE_0000 ^ 32'(s * 256 + r * 17);
   endfunction

   // Peripherals: register files whose q updates only on their own read strobe.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int s = 0; s < NSLOTS; s++) begin
            pq[s] <= 32'd0;
            for (int r = 0; r < 16; r++) pregs[s][r] <= seed_val(s, r);
         end
      end else begin
         for (int s = 0; s < NSLOTS; s++) begin
            if (bus.per_clken[s] && bus.per_wren) pregs[s][bus.per_address] <= bus.per_data;
            if (bus.per_clken[s] && bus.per_rden) pq[s] <= pregs[s][bus.per_address];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the IDLE cycle after the response.
   task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic hold);
      logic [3:0]  slot;
      logic        mapped;
      logic [31:0] exp_rdata;
      int          si, ri, exp_lat, strobes, strobe_at, resp_at, waited;
      slot      = addr[7:4];
      si        = int'(slot);
      ri        = int'(addr[3:0]);
      mapped    = (si < NSLOTS);
      exp_lat   = !mapped ? 1 : (we ? 2 : 3);
      exp_rdata = 32'd0;
      if (mapped && !we) exp_rdata = ref_mem[si][ri];
      if (mapped && we) ref_mem[si][ri] = wdata;

      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      waited = 0;
      while (!bus.req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check_eq("accept_wait", 32'(waited < 10), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;

      strobes = 0;
      strobe_at = 0;
      resp_at = 0;
      for (int k = 1; k <= 5 && resp_at == 0; k++) begin
         @(negedge clk);
         check_eq("busy_ready", 32'(bus.req_ready), 32'd0);
         if ((|bus.per_clken) || bus.per_rden || bus.per_wren) begin
            strobes++;
            strobe_at = k;
            strobe_cyc_q.push_back(cyc);
            check_eq("strobe_clken", 32'(bus.per_clken), mapped ? (32'd1 << slot) : 32'd0);
            check_eq("strobe_wren", 32'(bus.per_wren), 32'(we));
            check_eq("strobe_rden", 32'(bus.per_rden), 32'(!we));
            check_eq("strobe_addr", 32'(bus.per_address), 32'(addr[3:0]));
            check_eq("strobe_data", bus.per_data, wdata);
         end
         if (bus.resp_valid) begin
            resp_at = k;
            check_eq("resp_rdata", bus.resp_rdata, exp_rdata);
            check_eq("resp_err", 32'(bus.resp_err), 32'(!mapped));
         end
      end
      check_eq("strobe_count", 32'(strobes), mapped ? 32'd1 : 32'd0);
      check_eq("strobe_cycle", 32'(strobe_at), mapped ? 32'd1 : 32'd0);
      check_eq("resp_latency", 32'(resp_at), 32'(exp_lat));
      @(negedge clk);
      check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
      check_eq("resp_pulse", 32'(bus.resp_valid), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
      check_eq({tag, "_rdata"}, bus.resp_rdata, 32'd0);
      check_eq({tag, "_err"},   32'(bus.resp_err), 32'd0);
      check_eq({tag, "_clken"}, 32'(bus.per_clken), 32'd0);
      check_eq({tag, "_rden"},  32'(bus.per_rden), 32'd0);
      check_eq({tag, "_wren"},  32'(bus.per_wren), 32'd0);
      check_eq({tag, "_addr"},  32'(bus.per_address), 32'd0);
      check_eq({tag, "_data"},  bus.per_data, 32'd0);
      check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      logic [3:0] s;
      for (int si = 0; si < NSLOTS; si++)
         for (int r = 0; r < 16; r++) ref_mem[si][r] = seed_val(si, r);
      rst = 1'b1;
      mem_init = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_addr = 8'h00;
      bus.req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);
      check_eq("post_reset_ready", 32'(bus.req_ready), 32'd1);

      do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b1, 8'h14, 32'h0000_A5A5, 1'b0);
      do_req(1'b0, 8'h14, 32'd0, 1'b0);
      do_req(1'b1, 8'h22, 32'h1111_1111, 1'b0);
      do_req(1'b0, 8'h22, 32'd0, 1'b0);
      do_req(1'b1, 8'h23, 32'h2222_2222, 1'b0);
      do_req(1'b0, 8'h23, 32'd0, 1'b0);
      do_req(1'b0, 8'h50, 32'd0, 1'b0);

      strobe_cyc_q.delete();
      do_req(1'b1, 8'h00, 32'hA000_0000, 1'b1);
      do_req(1'b1, 8'h01, 32'hA000_0001, 1'b1);
      do_req(1'b1, 8'h02, 32'hA000_0002, 1'b0);
      check_eq("b2b_strobes", 32'(strobe_cyc_q.size()), 32'd3);
      if (strobe_cyc_q.size() == 3) begin
         check_eq("b2b_gap1", 32'(strobe_cyc_q[1] - strobe_cyc_q[0]), 32'd3);
         check_eq("b2b_gap2", 32'(strobe_cyc_q[2] - strobe_cyc_q[1]), 32'd3);
      end
      for (int i = 0; i < 3; i++) do_req(1'b0, 8'(i), 32'd0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         s = ($urandom_range(0, 7) == 7) ? 4'hF : 4'($urandom_range(0, 5));
         a = {s, 4'($urandom_range(0, 15))};
         do_req(1'($urandom_range(0, 1)), a, $urandom, (n == 39) ? 1'b0 : 1'($urandom_range(0, 1)));
      end

      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_addr = 8'h30;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("abort_strobe_rden", 32'(bus.per_rden), 32'd1);
      @(negedge clk);
      check_eq("abort_capture_rden", 32'(bus.per_rden), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("abort");
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_ready", 32'(bus.req_ready), 32'd1);
      check_eq("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      do_req(1'b1, 8'h00, 32'h5A5A_0F0F, 1'b0);
      do_req(1'b0, 8'h00, 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
